// File: rtl/serdes_pkg.sv
// Shared constants and state encoding for the serial lane scheduler.
package serdes_pkg;

   localparam int BYTE_BITS = 8;
   localparam logic [7:0] IDLE_BYTE = 8'hBC;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   // Index width that stays legal for a count of 1.
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_lane_scheduler_if.sv
// Lane request bus and serializer-facing outputs of the serial lane scheduler.
interface serial_lane_scheduler_if
   import serdes_pkg::*;
#(
   parameter int N_LANES = 4
);
   localparam int LW = lane_w(N_LANES);

   // Handshake: lane i transfers req_data[8i+7:8i] in the cycle where
   // req_valid[i] & req_ready[i]; req_ready is a one-hot pulse that only
   // occurs in the byte-boundary cycle, and valid may drop with no penalty.
   logic [N_LANES-1:0]   req_valid;
   logic [8*N_LANES-1:0] req_data;
   logic [N_LANES-1:0]   req_ready;
   logic [BYTE_BITS-1:0] ser_data;
   logic                 ser_enb;
   logic                 ser_load;
   logic [2:0]           bit_cnt;
   logic [LW-1:0]        lane_id;
   logic                 link_up;

   modport master (
      output req_valid, req_data,
      input  req_ready, ser_data, ser_enb, ser_load, bit_cnt, lane_id, link_up
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, ser_data, ser_enb, ser_load, bit_cnt, lane_id, link_up
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin lane picker: combinational grant searched from last_grant+1,
// pointer moves to the winner only when the top reports a completed handshake.
module rr_arbiter
   import serdes_pkg::lane_w;
#(
   parameter int N_LANES = 4,
   localparam int LW = lane_w(N_LANES)
) (
   input  logic               clk,
   input  logic               reset_L,
   input  logic [N_LANES-1:0] req_valid_i,
   input  logic               advance_i,
   output logic [N_LANES-1:0] grant_o,
   output logic [LW-1:0]      grant_idx_o,
   output logic               grant_any_o
);

   logic [LW-1:0] last_grant_q;

   always_comb begin
      int idx;
      logic [LW-1:0] sel;
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      idx         = 0;
      sel         = '0;
      for (int k = 1; k <= N_LANES; k++) begin
         idx = (int'(last_grant_q) + k) % N_LANES;
         sel = LW'(idx);
         if (!grant_any_o && req_valid_i[sel]) begin
            grant_any_o  = 1'b1;
            grant_o[sel] = 1'b1;
            grant_idx_o  = sel;
         end
      end
   end

   // Reset value points at the last lane so lane 0 is searched first.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         last_grant_q <= LW'(N_LANES - 1);
      end else if (advance_i) begin
         last_grant_q <= grant_idx_o;
      end
   end

endmodule

// File: rtl/serial_lane_scheduler.sv
// Shares one 8-bit serializer among N_LANES byte sources: comma preamble after
// reset, then one round-robin pick per byte boundary, idle bytes when nothing to send.
module serial_lane_scheduler
   import serdes_pkg::state_t, serdes_pkg::ST_INIT, serdes_pkg::ST_RUN,
          serdes_pkg::ST_PAUSE, serdes_pkg::BYTE_BITS, serdes_pkg::lane_w;
#(
   parameter int         N_LANES    = 4,
   parameter int         SYNC_BYTES = 4,
   parameter logic [7:0] IDLE_BYTE  = serdes_pkg::IDLE_BYTE
) (
   input  logic                    clk,
   input  logic                    reset_L,
   input  logic                    en,
   serial_lane_scheduler_if.slave  bus,
   output state_t                  state_o
);

   localparam int LW = lane_w(N_LANES);
   localparam int SW = lane_w(SYNC_BYTES);
   localparam int CW = $clog2(BYTE_BITS);

   state_t               state_q, state_d;
   logic [CW-1:0]        bit_cnt_q;
   logic [SW-1:0]        sync_cnt_q, sync_cnt_d;
   logic [BYTE_BITS-1:0] ser_data_q, ser_data_d;
   logic                 ser_enb_q, ser_enb_d;
   logic [LW-1:0]        lane_id_q, lane_id_d;

   logic [N_LANES-1:0]   grant;
   logic [LW-1:0]        grant_idx;
   logic                 grant_any;
   logic                 boundary;
   logic                 sync_last;
   logic                 arb_en;
   logic                 handshake;

   assign boundary  = (bit_cnt_q == CW'(BYTE_BITS - 1));
   assign sync_last = (sync_cnt_q == SW'(SYNC_BYTES - 1));
   // The last preamble boundary already arbitrates, so the first data byte
   // follows the comma sequence with no gap.
   assign arb_en    = boundary & en & ((state_q != ST_INIT) | sync_last);
   assign handshake = arb_en & grant_any;

   rr_arbiter #(.N_LANES(N_LANES)) u_arb (
      .clk         (clk),
      .reset_L     (reset_L),
      .req_valid_i (bus.req_valid),
      .advance_i   (handshake),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_any_o (grant_any)
   );

   always_comb begin
      state_d    = state_q;
      sync_cnt_d = sync_cnt_q;
      ser_data_d = ser_data_q;
      ser_enb_d  = ser_enb_q;
      lane_id_d  = lane_id_q;
      if (boundary) begin
         if ((state_q != ST_INIT) || sync_last) begin
            state_d = en ? ST_RUN : ST_PAUSE;
         end else begin
            sync_cnt_d = sync_cnt_q + 1'b1;
         end
         if (handshake) begin
            ser_data_d = bus.req_data[{grant_idx, 3'b000} +: BYTE_BITS];
            ser_enb_d  = 1'b1;
            lane_id_d  = grant_idx;
         end else begin
            ser_data_d = IDLE_BYTE;
            ser_enb_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= ST_INIT;
         bit_cnt_q  <= '0;
         sync_cnt_q <= '0;
         ser_data_q <= IDLE_BYTE;
         ser_enb_q  <= 1'b0;
         lane_id_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_q + 1'b1;
         sync_cnt_q <= sync_cnt_d;
         ser_data_q <= ser_data_d;
         ser_enb_q  <= ser_enb_d;
         lane_id_q  <= lane_id_d;
      end
   end

   assign bus.req_ready = arb_en ? grant : '0;
   assign bus.ser_data  = ser_data_q;
   assign bus.ser_enb   = ser_enb_q;
   assign bus.ser_load  = (bit_cnt_q == '0);
   assign bus.bit_cnt   = bit_cnt_q;
   assign bus.lane_id   = lane_id_q;
   assign bus.link_up   = (state_q != ST_INIT);
   assign state_o       = state_q;

endmodule

// File: tb/tb_serial_lane_scheduler.sv
// Bench for serial_lane_scheduler: byte-level behavioural model with a
// scoreboard queue, directed scenarios with literal expectations, random traffic.
module tb_serial_lane_scheduler;

   localparam int N = 4;
   localparam int SYNC = 4;
   localparam logic [7:0] IDLE = 8'hBC;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   logic en = 1'b0;
   logic [N-1:0]   valid_v = '0;
   logic [8*N-1:0] data_v = '0;
   serdes_pkg::state_t dut_state;

   serial_lane_scheduler_if #(.N_LANES(N)) bus ();

   assign bus.req_valid = valid_v;
   assign bus.req_data  = data_v;

   serial_lane_scheduler #(
      .N_LANES    (N),
      .SYNC_BYTES (SYNC),
      .IDLE_BYTE  (IDLE)
   ) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .en      (en),
      .bus     (bus),
      .state_o (dut_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: cycle index since reset release, boundaries seen, RR pointer,
   // and the byte currently on the serializer.
   int         m_cyc = 0;
   int         m_nb = 0;
   int         m_last = N - 1;
   logic [7:0] m_data = IDLE;
   logic       m_enb = 1'b0;
   int         m_lane = 0;
   logic [15:0] exp_q[$];

   always @(negedge clk) begin
      int bc;
      int win;
      int l;
      logic [N-1:0] exp_rdy;
      logic [15:0] e;
      if (!reset_L) begin
         check("rst_bit_cnt", bus.bit_cnt, 0);
         check("rst_ser_load", bus.ser_load, 1);
         check("rst_ser_data", bus.ser_data, IDLE);
         check("rst_ser_enb", bus.ser_enb, 0);
         check("rst_req_ready", bus.req_ready, 0);
         check("rst_lane_id", bus.lane_id, 0);
         check("rst_link_up", bus.link_up, 0);
         check("rst_state_init", dut_state == serdes_pkg::ST_INIT, 1);
         m_cyc = 0;
         m_nb = 0;
         m_last = N - 1;
         m_data = IDLE;
         m_enb = 1'b0;
         m_lane = 0;
         exp_q.delete();
      end else begin
         bc = m_cyc % 8;
         if (bc == 0) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               m_lane = int'(e[15:8]);
               m_data = e[7:0];
               m_enb = 1'b1;
            end else begin
               m_data = IDLE;
               m_enb = 1'b0;
            end
         end
         check("bit_cnt", bus.bit_cnt, bc);
         check("ser_load", bus.ser_load, bc == 0);
         check("link_up", bus.link_up, m_nb >= SYNC);
         check("ser_data", bus.ser_data, m_data);
         check("ser_enb", bus.ser_enb, m_enb);
         check("lane_id", bus.lane_id, m_lane);
         exp_rdy = '0;
         win = -1;
         if (bc == 7) begin
            if (en && (m_nb >= SYNC - 1)) begin
               for (int k = 1; k <= N; k++) begin
                  l = (m_last + k) % N;
                  if (win < 0 && valid_v[l]) win = l;
               end
            end
            if (win >= 0) begin
               exp_rdy[win] = 1'b1;
               m_last = win;
               exp_q.push_back({8'(win), data_v[8*win +: 8]});
            end
            m_nb++;
         end
         check("req_ready", bus.req_ready, exp_rdy);
         m_cyc++;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all_lanes_10();
      valid_v = '1;
      for (int i = 0; i < N; i++) data_v[8*i +: 8] = 8'h10 + 8'(i);
   endtask

   initial begin
      int pulses;
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_L = 1'b1;

      // Preamble with no requests: idle bytes, link_up after the 4th boundary.
      for (int c = 0; c < 48; c++) begin
         if (c == 31) check("p1_link_down_c31", bus.link_up, 0);
         if (c == 32) check("p1_link_up_c32", bus.link_up, 1);
         if (c % 8 == 0) check("p1_idle_byte", {bus.ser_enb, bus.ser_data}, {1'b0, IDLE});
         tick();
      end

      // All lanes valid: 10,11,12,13 repeating, one grant pulse per byte.
      set_all_lanes_10();
      repeat (8) tick();
      for (int j = 0; j < 8; j++) begin
         check("p2_data", bus.ser_data, 8'h10 + 8'(j % 4));
         check("p2_lane", bus.lane_id, j % 4);
         check("p2_enb", bus.ser_enb, 1);
         pulses = 0;
         for (int b = 0; b < 8; b++) begin
            pulses += $countones(bus.req_ready);
            tick();
         end
         check("p2_pulses_per_byte", pulses, 1);
      end

      // Only lane 2 valid, then lane 0 joins: search from 3 wraps to lane 0.
      valid_v = 4'b0100;
      data_v[16 +: 8] = 8'hA5;
      repeat (8) tick();
      for (int j = 0; j < 3; j++) begin
         check("p3_a5_data", bus.ser_data, 8'hA5);
         check("p3_a5_lane", bus.lane_id, 2);
         repeat (8) tick();
      end
      valid_v = 4'b0101;
      data_v[0 +: 8] = 8'h5A;
      repeat (8) tick();
      check("p3_lane0_wins", {bus.lane_id, bus.ser_data}, {2'd0, 8'h5A});
      repeat (8) tick();
      check("p3_lane2_next", {bus.lane_id, bus.ser_data}, {2'd2, 8'hA5});

      // en dropped mid-byte in RUN.
      set_all_lanes_10();
      repeat (8) tick();
      repeat (3) tick();
      en = 1'b0;
      repeat (4) tick();
      check("p4_byte_completes", {bus.ser_enb, bus.ser_data}, {1'b1, 8'h13});
      tick();
      check("p4_idle_after_pause", {bus.ser_enb, bus.ser_data}, {1'b0, IDLE});
      check("p4_link_stays_up", bus.link_up, 1);
      pulses = 0;
      for (int c = 184; c < 199; c++) begin
         if (c == 192) check("p4_still_idle", {bus.ser_enb, bus.ser_data}, {1'b0, IDLE});
         if (c == 195) en = 1'b1;
         pulses += $countones(bus.req_ready);
         tick();
      end
      check("p4_no_grant_paused", pulses, 0);
      check("p4_resume_grant", bus.req_ready, 4'b0001);
      tick();
      check("p4_resume_data", {bus.ser_enb, bus.lane_id, bus.ser_data}, {1'b1, 2'd0, 8'h10});

      // Asynchronous reset at bit 4 of a data byte.
      repeat (4) tick();
      check("p5_pre_bitcnt", bus.bit_cnt, 4);
      check("p5_pre_enb", bus.ser_enb, 1);
      reset_L = 1'b0;
      #1;
      check("p5_async_bitcnt", bus.bit_cnt, 0);
      check("p5_async_load", bus.ser_load, 1);
      check("p5_async_data", {bus.ser_enb, bus.ser_data}, {1'b0, IDLE});
      check("p5_async_ready", bus.req_ready, 0);
      check("p5_async_lane_link", {bus.lane_id, bus.link_up}, {2'd0, 1'b0});
      @(posedge clk);
      #1 reset_L = 1'b1;

      // Sync re-sent, then lane 1 drops valid just before its turn.
      for (int c = 0; c < 66; c++) begin
         if (c < 32 && c % 8 == 0) check("p5_resync_idle", {bus.ser_enb, bus.ser_data}, {1'b0, IDLE});
         if (c == 31) check("p5_link_down_c31", bus.link_up, 0);
         if (c == 32) check("p5_first_data", {bus.link_up, bus.lane_id, bus.ser_data}, {1'b1, 2'd0, 8'h10});
         if (c == 38) valid_v = 4'b1101;
         if (c == 39) check("p6_grant_skips_lane1", bus.req_ready, 4'b0100);
         if (c == 40) begin
            check("p6_lane2_data", {bus.lane_id, bus.ser_data}, {2'd2, 8'h12});
            valid_v = 4'b1111;
         end
         if (c == 64) check("p6_lane1_kept", {bus.lane_id, bus.ser_data}, {2'd1, 8'h11});
         tick();
      end

      // Random traffic against the model.
      for (int c = 0; c < 2400; c++) begin
         if ($urandom_range(0, 4) == 0) begin
            valid_v = N'($urandom_range(0, (1 << N) - 1));
            data_v = $urandom;
         end
         if ($urandom_range(0, 7) == 0) en = ($urandom_range(0, 3) != 0);
         tick();
      end

      valid_v = '0;
      repeat (24) tick();
      check("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
